// File: rtl/uart_rx_word.sv
// uart_rx_word: oversampling 8N1 receiver that pairs bytes (low first) into 16-bit words
// behind a one-entry valid/ready holding register, flagging framing errors and overruns.
module uart_rx_word #(
    parameter int DATA_WIDTH   = 16,
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clken,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  rx_busy
);
    localparam int TW    = $clog2(OVERSAMPLE);
    localparam int LIMIT = TIMEOUT_BITS * OVERSAMPLE;
    localparam int IW    = $clog2(LIMIT + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_q, rx_s;
    logic [TW-1:0] tick;
    logic [2:0]    bit_idx;
    logic          byte_idx;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    shift, low;
    logic          tick_end, stop_smp, word_done;

    assign tick_end  = tick == TW'(OVERSAMPLE - 1);
    assign stop_smp  = clken && state == STOP && tick_end;
    assign word_done = stop_smp && rx_s && byte_idx;
    assign rx_busy   = state != IDLE || byte_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            byte_idx  <= 1'b0;
            idle_cnt  <= '0;
            shift     <= '0;
            low       <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_q      <= rx;
            rx_s      <= rx_q;
            frame_err <= stop_smp && !rx_s;
            overrun   <= word_done && valid && !ready;
            if (word_done && (!valid || ready)) begin
                data_out <= {shift, low};
                valid    <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
            if (clken) begin
                case (state)
                    IDLE: begin
                        tick     <= '0;
                        idle_cnt <= byte_idx ? idle_cnt + 1'b1 : '0;
                        // timeout wins over a simultaneous start edge: new frame becomes byte 0
                        if (byte_idx && idle_cnt == IW'(LIMIT - 1)) begin
                            byte_idx <= 1'b0;
                            idle_cnt <= '0;
                        end
                        if (!rx_s) begin
                            state    <= START;
                            idle_cnt <= '0;
                        end
                    end
                    START: begin
                        tick <= tick + 1'b1;
                        if (tick == TW'(OVERSAMPLE / 2 - 1)) begin
                            tick    <= '0;
                            bit_idx <= '0;
                            state   <= rx_s ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        tick <= tick + 1'b1;
                        if (tick_end) begin
                            tick           <= '0;
                            shift[bit_idx] <= rx_s;
                            bit_idx        <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) state <= STOP;
                        end
                    end
                    STOP: begin
                        tick <= tick + 1'b1;
                        if (tick_end) begin
                            tick     <= '0;
                            state    <= IDLE;
                            byte_idx <= rx_s && !byte_idx;
                            if (rx_s && !byte_idx) low <= shift;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed frames on rx; a queue of expected words is checked by a
// monitor at every valid/ready handshake, and flag pulses are counted per cycle.
module tb_uart_rx_word;
    logic        clk = 0, rst, clken, rx, ready;
    logic [15:0] data_out;
    logic        valid, frame_err, overrun, rx_busy;
    logic [15:0] q[$];
    int          total = 0, bad = 0, hs_cnt = 0, fe_cnt = 0, ov_cnt = 0;

    uart_rx_word #(.DATA_WIDTH(16), .OVERSAMPLE(16), .TIMEOUT_BITS(16)) dut (
        .clk(clk), .rst(rst), .clken(clken), .rx(rx), .data_out(data_out), .valid(valid),
        .ready(ready), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                hs_cnt++;
                if (q.size() == 0) chk("unexpected_word", int'(data_out), -1);
                else chk("word", int'(data_out), int'(q.pop_front()));
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        step(16);
    endtask

    task automatic send(input logic [7:0] b, input logic sb, input int extra);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(sb);
        repeat (extra) bit_out(1'b1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) bit_out(1'b1);
    endtask

    initial begin
        rst = 1; rx = 1; ready = 1; clken = 1;
        step(3);
        @(negedge clk);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_rx_busy", int'(rx_busy), 0);
        step(1);
        rst = 0;
        step(4);

        q.push_back(16'hA55A);
        send(8'h5A, 1'b1, 1);
        send(8'hA5, 1'b1, 1);
        idle_bits(3);
        chk("t1_hs", hs_cnt, 1);
        chk("t1_valid_dropped", int'(valid), 0);
        chk("t1_no_flags", fe_cnt + ov_cnt, 0);

        rx = 0;
        step(4);
        rx = 1;
        step(24);
        chk("glitch_busy", int'(rx_busy), 0);
        q.push_back(16'h1234);
        send(8'h34, 1'b1, 1);
        send(8'h12, 1'b1, 1);
        idle_bits(3);
        chk("t2_hs", hs_cnt, 2);

        send(8'h77, 1'b1, 1);
        send(8'h88, 1'b0, 2);
        idle_bits(2);
        chk("fe_count", fe_cnt, 1);
        chk("fe_no_word", hs_cnt, 2);
        chk("fe_busy", int'(rx_busy), 0);
        q.push_back(16'hABCD);
        send(8'hCD, 1'b1, 1);
        send(8'hAB, 1'b1, 1);
        idle_bits(3);
        chk("t3_hs", hs_cnt, 3);

        ready = 0;
        q.push_back(16'h1111);
        send(8'h11, 1'b1, 2);
        send(8'h11, 1'b1, 2);
        send(8'h22, 1'b1, 2);
        send(8'h22, 1'b1, 2);
        idle_bits(2);
        chk("ov_data_hold", int'(data_out), 16'h1111);
        chk("ov_valid_hold", int'(valid), 1);
        chk("ov_count", ov_cnt, 1);
        ready = 1;
        step(2);
        @(negedge clk);
        chk("ov_valid_clear", int'(valid), 0);
        chk("ov_hs", hs_cnt, 4);
        chk("ov_data_kept", int'(data_out), 16'h1111);
        step(1);

        q.push_back(16'h5612);
        send(8'h34, 1'b1, 1);
        chk("held_low_busy", int'(rx_busy), 1);
        idle_bits(20);
        chk("timeout_busy", int'(rx_busy), 0);
        send(8'h12, 1'b1, 1);
        send(8'h56, 1'b1, 1);
        idle_bits(3);
        chk("t5_hs", hs_cnt, 5);

        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        rx = 1;
        step(5);
        rst = 1;
        step(1);
        @(negedge clk);
        chk("mid_rst_data_out", int'(data_out), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_busy", int'(rx_busy), 0);
        chk("mid_rst_flags", int'(frame_err) + int'(overrun), 0);
        step(1);
        rst = 0;
        idle_bits(3);
        q.push_back(16'hBEEF);
        send(8'hEF, 1'b1, 1);
        send(8'hBE, 1'b1, 1);
        for (int i = 0; i < 1000 && q.size() != 0; i++) step(1);
        chk("queue_drained", q.size(), 0);
        chk("final_hs", hs_cnt, 6);
        chk("final_fe", fe_cnt, 1);
        chk("final_ov", ov_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
